// File: rtl/stream_demux_if.sv
// Valid/ready bundle for stream_demux: one producer-side stream plus NUM_CH consumer lanes.
// The slave modport is the demux's view; the master modport is the surrounding system's view.
interface stream_demux_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 8
);
    localparam int SEL_WIDTH = $clog2(NUM_CH);

    logic [SEL_WIDTH-1:0]         sel_i;
    logic                         s_valid_i;
    logic                         s_ready_o;
    logic [DATA_WIDTH-1:0]        s_data_i;
    logic [NUM_CH-1:0]            m_valid_o;
    logic [NUM_CH-1:0]            m_ready_i;
    logic [NUM_CH*DATA_WIDTH-1:0] m_data_o;
    logic                         err_o;

    modport slave (
        input  sel_i, s_valid_i, s_data_i, m_ready_i,
        output s_ready_o, m_valid_o, m_data_o, err_o
    );

    modport master (
        output sel_i, s_valid_i, s_data_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_data_o, err_o
    );
endinterface

// File: rtl/stream_demux.sv
// Registered 1-to-NUM_CH valid/ready stream demultiplexer with out-of-range select detection.
// Optional per-channel delivered-beat counters are built when STREAM_DEMUX_STATS_EN is defined.
module stream_demux #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk_i,
    input  logic                        arst_i,
    stream_demux_if.slave               bus
`ifdef STREAM_DEMUX_STATS_EN
    ,
    input  logic                        cnt_clr_i,
    output logic [NUM_CH*CNT_WIDTH-1:0] ch_cnt_o
`endif
);
    localparam int SEL_WIDTH = $clog2(NUM_CH);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e                state_q;
    logic [NUM_CH-1:0]     valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;

    logic [NUM_CH-1:0]     selOneHot;
    logic                  selInRange;
    logic                  outHs;
    logic                  accept;
    logic                  load;

    // A select value with no matching channel decodes to all zeros, which doubles as the range check.
    always_comb begin
        selOneHot = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            selOneHot[k] = (bus.sel_i == SEL_WIDTH'(k));
        end
    end

    assign selInRange    = |selOneHot;
    assign outHs         = |(valid_q & bus.m_ready_i);
    assign bus.s_ready_o = (state_q == EMPTY) | outHs;
    assign accept        = bus.s_valid_i & bus.s_ready_o;
    assign load          = accept & selInRange;

    // valid_q is the one-hot destination of the held beat, so it serves as both dest and m_valid_o.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= EMPTY;
            valid_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept & ~selInRange;
            case (state_q)
                EMPTY: begin
                    if (load) begin
                        state_q <= FULL;
                        valid_q <= selOneHot;
                        data_q  <= bus.s_data_i;
                    end
                end
                FULL: begin
                    if (load) begin
                        valid_q <= selOneHot;
                        data_q  <= bus.s_data_i;
                    end else if (outHs) begin
                        state_q <= EMPTY;
                        valid_q <= '0;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    valid_q <= '0;
                end
            endcase
        end
    end

    assign bus.m_valid_o = valid_q;
    assign bus.err_o     = err_q;

    always_comb begin
        bus.m_data_o = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            bus.m_data_o[k*DATA_WIDTH +: DATA_WIDTH] = valid_q[k] ? data_q : '0;
        end
    end

`ifdef STREAM_DEMUX_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];

    // Saturating counters; a clear wins over an increment landing in the same cycle.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (cnt_clr_i) begin
                    cnt_q[k] <= '0;
                end else if (valid_q[k] && bus.m_ready_i[k] && (cnt_q[k] != '1)) begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        ch_cnt_o = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_cnt_o[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
        end
    end
`endif
endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: an 8-channel instance driven from a vector table plus a
// 5-channel instance for out-of-range selects; counter checks run when STREAM_DEMUX_STATS_EN is set.
module tb_stream_demux;
    localparam int DW = 32;

    typedef struct {
        logic [2:0]  sel;
        logic        valid;
        logic [31:0] data;
        logic [7:0]  mready;
        logic [7:0]  expValid;
        logic [31:0] expData;
        logic        expReady;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    stream_demux_if #(.DATA_WIDTH(DW), .NUM_CH(8)) bus8 ();
    stream_demux_if #(.DATA_WIDTH(DW), .NUM_CH(5)) bus5 ();

`ifdef STREAM_DEMUX_STATS_EN
    logic          clr8 = 1'b0;
    logic          clr5 = 1'b0;
    logic [31:0]   cnt8;
    logic [79:0]   cnt5;
`endif

    stream_demux #(.DATA_WIDTH(DW), .NUM_CH(8), .CNT_WIDTH(4)) dut8 (
        .clk_i(clk), .arst_i(rst), .bus(bus8)
`ifdef STREAM_DEMUX_STATS_EN
        , .cnt_clr_i(clr8), .ch_cnt_o(cnt8)
`endif
    );

    stream_demux #(.DATA_WIDTH(DW), .NUM_CH(5)) dut5 (
        .clk_i(clk), .arst_i(rst), .bus(bus5)
`ifdef STREAM_DEMUX_STATS_EN
        , .cnt_clr_i(clr5), .ch_cnt_o(cnt5)
`endif
    );

    function automatic logic [255:0] expBus(input logic [7:0] v, input logic [31:0] d);
        logic [255:0] r = '0;
        for (int k = 0; k < 8; k++) if (v[k]) r[k*32 +: 32] = d;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge; returns at the following falling edge.
    task automatic applyStimulus(input bit toFive, input logic [2:0] sel, input logic valid,
                                 input logic [31:0] data, input logic [7:0] mready);
        @(posedge clk);
        #1;
        bus8.s_valid_i = 1'b0;
        bus5.s_valid_i = 1'b0;
        if (toFive) begin
            bus5.sel_i = sel; bus5.s_valid_i = valid; bus5.s_data_i = data; bus5.m_ready_i = mready[4:0];
        end else begin
            bus8.sel_i = sel; bus8.s_valid_i = valid; bus8.s_data_i = data; bus8.m_ready_i = mready;
        end
        @(negedge clk);
    endtask

    task automatic addVec(input int sel, input logic valid, input logic [31:0] data, input logic [7:0] mready,
                          input logic [7:0] ev, input logic [31:0] ed, input logic er);
        vec_t v;
        v.sel = 3'(sel); v.valid = valid; v.data = data; v.mready = mready;
        v.expValid = ev; v.expData = ed; v.expReady = er;
        vecs.push_back(v);
    endtask

    initial begin
        bus8.sel_i = '0; bus8.s_valid_i = 1'b0; bus8.s_data_i = '0; bus8.m_ready_i = '0;
        bus5.sel_i = '0; bus5.s_valid_i = 1'b0; bus5.s_data_i = '0; bus5.m_ready_i = '0;

        // Back-to-back sweep over all channels, then idle.
        for (int k = 0; k < 8; k++)
            addVec(k, 1'b1, 32'hA000_0000 | k, 8'hFF, (k == 0) ? 8'h00 : 8'(1 << (k - 1)),
                   32'hA000_0000 | (k - 1), 1'b1);
        addVec(0, 1'b0, 32'h0, 8'hFF, 8'h80, 32'hA000_0007, 1'b1);
        addVec(0, 1'b0, 32'h0, 8'hFF, 8'h00, 32'h0, 1'b1);
        // Channel 3 stalls for five cycles while a beat for channel 5 waits.
        addVec(3, 1'b1, 32'hDEAD_BEEF, 8'hFF, 8'h00, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++)
            addVec(5, 1'b1, 32'h5555_5555, 8'hF7, 8'h08, 32'hDEAD_BEEF, 1'b0);
        addVec(5, 1'b1, 32'h5555_5555, 8'hFF, 8'h08, 32'hDEAD_BEEF, 1'b1);
        addVec(0, 1'b0, 32'h0, 8'hFF, 8'h20, 32'h5555_5555, 1'b1);
        addVec(0, 1'b0, 32'h0, 8'hFF, 8'h00, 32'h0, 1'b1);
        // Simultaneous handshake and reload across different channels.
        addVec(6, 1'b1, 32'h0000_0066, 8'hFF, 8'h00, 32'h0, 1'b1);
        addVec(1, 1'b1, 32'h0000_0011, 8'hFF, 8'h40, 32'h0000_0066, 1'b1);
        addVec(0, 1'b0, 32'h0, 8'hFF, 8'h02, 32'h0000_0011, 1'b1);
        addVec(0, 1'b0, 32'h0, 8'hFF, 8'h00, 32'h0, 1'b1);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mvalid", 256'(bus8.m_valid_o), 256'h0);
        checkOutput("rst_mdata", bus8.m_data_o, 256'h0);
        checkOutput("rst_err", 256'(bus8.err_o), 256'h0);
        rst = 1'b0;
        #1;
        checkOutput("rst_sready", 256'(bus8.s_ready_o), 256'h1);

        foreach (vecs[i]) begin
            applyStimulus(1'b0, vecs[i].sel, vecs[i].valid, vecs[i].data, vecs[i].mready);
            checkOutput($sformatf("vec%0d_mvalid", i), 256'(bus8.m_valid_o), 256'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d_mdata", i), bus8.m_data_o, expBus(vecs[i].expValid, vecs[i].expData));
            checkOutput($sformatf("vec%0d_sready", i), 256'(bus8.s_ready_o), 256'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d_err", i), 256'(bus8.err_o), 256'h0);
        end

        // Out-of-range select on the 5-channel instance, followed by a normal beat.
        applyStimulus(1'b1, 3'd6, 1'b1, 32'h0000_1234, 8'h1F);
        checkOutput("oor_sready", 256'(bus5.s_ready_o), 256'h1);
        checkOutput("oor_mvalid0", 256'(bus5.m_valid_o), 256'h0);
        applyStimulus(1'b1, 3'd2, 1'b1, 32'h0000_2222, 8'h1F);
        checkOutput("oor_err", 256'(bus5.err_o), 256'h1);
        checkOutput("oor_mvalid1", 256'(bus5.m_valid_o), 256'h0);
        checkOutput("oor_mdata1", 256'(bus5.m_data_o), 256'h0);
        applyStimulus(1'b1, 3'd0, 1'b0, 32'h0, 8'h1F);
        checkOutput("oor_err_pulse", 256'(bus5.err_o), 256'h0);
        checkOutput("oor_next_mvalid", 256'(bus5.m_valid_o), 256'h04);
        checkOutput("oor_next_mdata", 256'(bus5.m_data_o), 256'h0000_2222 << 64);
        applyStimulus(1'b1, 3'd0, 1'b0, 32'h0, 8'h1F);
        checkOutput("oor_drain", 256'(bus5.m_valid_o), 256'h0);

        // Asynchronous reset while a stalled beat is held.
        applyStimulus(1'b0, 3'd2, 1'b1, 32'hCAFE_0002, 8'h00);
        applyStimulus(1'b0, 3'd0, 1'b0, 32'h0, 8'h00);
        checkOutput("held_mvalid", 256'(bus8.m_valid_o), 256'h04);
        checkOutput("held_sready", 256'(bus8.s_ready_o), 256'h0);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_mvalid", 256'(bus8.m_valid_o), 256'h0);
        checkOutput("async_mdata", bus8.m_data_o, 256'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_sready", 256'(bus8.s_ready_o), 256'h1);
        applyStimulus(1'b0, 3'd0, 1'b0, 32'h0, 8'h00);
        checkOutput("post_rst_mvalid", 256'(bus8.m_valid_o), 256'h0);

`ifdef STREAM_DEMUX_STATS_EN
        applyStimulus(1'b0, 3'd0, 1'b0, 32'h0, 8'hFF);
        clr8 = 1'b1;
        applyStimulus(1'b0, 3'd0, 1'b0, 32'h0, 8'hFF);
        clr8 = 1'b0;
        checkOutput("cnt_cleared", 256'(cnt8), 256'h0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 3'd1, 1'b1, 32'(i), 8'hFF);
        repeat (2) applyStimulus(1'b0, 3'd0, 1'b0, 32'h0, 8'hFF);
        checkOutput("cnt_saturate", 256'(cnt8), 256'h0000_00F0);
        clr8 = 1'b1;
        applyStimulus(1'b0, 3'd0, 1'b0, 32'h0, 8'hFF);
        clr8 = 1'b0;
        repeat (2) applyStimulus(1'b0, 3'd1, 1'b1, 32'h0, 8'hFF);
        applyStimulus(1'b0, 3'd0, 1'b0, 32'h0, 8'hFF);
        checkOutput("cnt_two", 256'(cnt8), 256'h0000_0020);
        applyStimulus(1'b0, 3'd1, 1'b1, 32'h0, 8'hFF);
        applyStimulus(1'b0, 3'd0, 1'b0, 32'h0, 8'hFF);
        clr8 = 1'b1;
        applyStimulus(1'b0, 3'd0, 1'b0, 32'h0, 8'hFF);
        clr8 = 1'b0;
        checkOutput("cnt_clr_priority", 256'(cnt8), 256'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
